// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, bubble control zeroing and
// saturating stall counter. Define PIPE_STAGE_SKID_EN to compile in the 2-entry skid buffer.
module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds valid and its payload stable until ready is seen.
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_e;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1} state_e;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept;
  logic              emit;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic              in_ready_q;

  // in_ready is registered so out_ready never reaches upstream combinationally.
  assign in_ready = reset_n & in_ready_q;
`else
  assign in_ready = reset_n & (~out_valid | out_ready);
`endif

  assign out_valid   = (state_q != EMPTY);
  assign accept      = in_valid & in_ready;
  assign emit        = out_valid & out_ready;
  assign out_data    = m_data_q;
  assign out_ctrl    = out_valid ? m_ctrl_q : '0;
  assign stall_cnt   = stall_cnt_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    m_data_d    = m_data_q;
    m_ctrl_d    = m_ctrl_q;
    stall_cnt_d = stall_cnt_q;
`ifdef PIPE_STAGE_SKID_EN
    s_data_d    = s_data_q;
    s_ctrl_d    = s_ctrl_q;
`endif

    if (out_valid && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    if (flush) begin
      state_d = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
      s_data_d = '0;
      s_ctrl_d = '0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = FULL;
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end
        end
        FULL: begin
          if (accept && emit) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (emit) begin
            state_d = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept) begin
            state_d  = SKID;
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (emit) begin
            state_d  = FULL;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
            s_data_d = '0;
            s_ctrl_d = '0;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      m_data_q    <= '0;
      m_ctrl_q    <= '0;
      stall_cnt_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      s_data_q    <= '0;
      s_ctrl_q    <= '0;
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef PIPE_STAGE_SKID_EN
      s_data_q    <= s_data_d;
      s_ctrl_q    <= s_ctrl_d;
      in_ready_q  <= (state_d != SKID);
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; expectations follow PIPE_STAGE_SKID_EN where behaviour differs.
module tb_pipe_stage_reg;

  localparam int DATA_W = 16;
  localparam int CTRL_W = 6;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .flush      (flush),
    .stall_cnt  (stall_cnt),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    in_ctrl   = 6'h3f;
    out_ready = 1'b1;
    flush     = 1'b0;

    // Reset held two cycles with a valid input that must be ignored
    tick();
    chk("rst_in_ready_0", 32'(in_ready), 32'h0);
    tick();
    chk("rst_in_ready_1", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_ctrl", 32'(out_ctrl), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Streaming: 8 back-to-back bundles, each visible one edge after acceptance
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      in_ctrl  = 6'h3f;
      tick();
      chk("stream_valid", 32'(out_valid), 32'h1);
      chk("stream_data", 32'(out_data), 32'(i));
      chk("stream_ctrl", 32'(out_ctrl), 32'h3f);
    end
    chk("stream_stall_cnt", 32'(stall_cnt), 32'h0);

    // Bubble: control presented without valid never reaches out_ctrl
    in_valid = 1'b0;
    in_ctrl  = 6'h3f;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bubble_valid", 32'(out_valid), 32'h0);
      chk("bubble_ctrl", 32'(out_ctrl), 32'h0);
    end

    // Backpressure: out_ready low for 6 edges; A accepted at the first, stalls counted on the next 5
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00a0;
    in_ctrl   = 6'h21;
    tick();
    chk("bp_a_valid", 32'(out_valid), 32'h1);
    chk("bp_a_data", 32'(out_data), 32'h00a0);
    in_data = 16'h00b0;
    in_ctrl = 6'h22;
    tick();
    chk("bp_in_ready_low", 32'(in_ready), 32'h0);
`ifdef PIPE_STAGE_SKID_EN
    in_data = 16'h00c0;
    in_ctrl = 6'h23;
`endif
    for (int i = 0; i < 4; i++) tick();
    chk("bp_stall_cnt", 32'(stall_cnt), 32'h5);
    chk("bp_hold_data", 32'(out_data), 32'h00a0);
    chk("bp_hold_ctrl", 32'(out_ctrl), 32'h21);
    out_ready = 1'b1;
    tick();
    chk("bp_b_data", 32'(out_data), 32'h00b0);
    chk("bp_b_ctrl", 32'(out_ctrl), 32'h22);
`ifndef PIPE_STAGE_SKID_EN
    in_data = 16'h00c0;
    in_ctrl = 6'h23;
`endif
    tick();
    chk("bp_c_data", 32'(out_data), 32'h00c0);
    chk("bp_c_ctrl", 32'(out_ctrl), 32'h23);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid), 32'h0);
    chk("bp_cnt_kept", 32'(stall_cnt), 32'h5);

    // Flush with held bundles and a new valid input in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    in_ctrl   = 6'h3f;
    tick();
    in_data = 16'h0022;
    tick();
    flush   = 1'b1;
    in_data = 16'h0099;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_ctrl", 32'(out_ctrl), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    chk("flush_stall_cnt", 32'(stall_cnt), 32'h7);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_emit", 32'(out_valid), 32'h0);
    end

    // Saturation of a 4-bit stall counter, then reset clears it
    reset_n = 1'b0;
    tick();
    chk("sat_rst_cnt", 32'(stall_cnt), 32'h0);
    reset_n   = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0055;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("sat_cnt_15", 32'(stall_cnt), 32'hf);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_cnt_hold", 32'(stall_cnt), 32'hf);
    chk("sat_data", 32'(out_data), 32'h0055);
    reset_n = 1'b0;
    tick();
    chk("sat_rst_clear", 32'(stall_cnt), 32'h0);
    chk("sat_rst_valid", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
